gray_code_stream_conv: RTL and testbench

- Parametrised, pipelined, streaming code converter; successor to the team's fixed 4-bit combinational BCD-to-Gray converter.
- Converts N-bit words between binary, Gray and BCD-coded forms, with the mode selected per sample.
- Valid/ready handshake on both sides, 2-stage register pipeline, BCD digit range checking and a saturating error counter.
- Sits between a producer (counter/ADC/keypad decode) and a consumer (display, CDC synchroniser) needing Gray or binary.

---
 rtl/gray_code_stream_conv.sv | 120 ++++++++++++
 tb/tb_gray_code_stream_conv.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_code_stream_conv.sv
// rtl/gray_code_stream_conv.sv - two-stage streaming binary/Gray/BCD code converter
module gray_code_stream_conv #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [1:0]    in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          out_err,
    output logic [CW-1:0] err_cnt
);

    localparam logic [1:0] MODE_B2G  = 2'b00;
    localparam logic [1:0] MODE_G2B  = 2'b01;
    localparam logic [1:0] MODE_BCDG = 2'b10;
    localparam logic [1:0] MODE_PASS = 2'b11;

    // Stage 1 holding registers
    logic         v1;
    logic [N-1:0] d1;
    logic [1:0]   m1;

    // Stage 2 valid bit; data/err live directly in the output registers
    logic         v2;

    logic         ld1;
    logic         ld2;
    logic [N-1:0] conv_data;
    logic         conv_err;

    // Gray to binary is a running XOR from the MSB down to bit 0
    function automatic logic [N-1:0] gray_to_bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Flags any complete nibble holding a value outside 0..9
    function automatic logic bcd_bad(input logic [N-1:0] d);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k + 4 <= N; k += 4) begin
            if (d[k+:4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // A stage advances when it is empty or its downstream neighbour advances
    assign ld2       = !v2 || out_ready;
    assign ld1       = !v1 || ld2;
    assign in_ready  = ld1;
    assign out_valid = v2;

    // Conversion of the stage-1 word according to its captured mode
    always_comb begin
        conv_data = d1;
        conv_err  = 1'b0;
        case (m1)
            MODE_B2G:  conv_data = d1 ^ (d1 >> 1);
            MODE_G2B:  conv_data = gray_to_bin(d1);
            MODE_BCDG: begin
                conv_data = d1 ^ (d1 >> 1);
                conv_err  = bcd_bad(d1);
            end
            MODE_PASS: conv_data = d1;
            default:   conv_data = d1;
        endcase
    end

    // Stage 1: capture the accepted sample and its mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            d1 <= '0;
            m1 <= 2'b00;
        end else if (ld1) begin
            v1 <= in_valid;
            if (in_valid) begin
                d1 <= in_data;
                m1 <= in_mode;
            end
        end
    end

    // Stage 2: register the converted result; held stable while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2       <= 1'b0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                out_data <= conv_data;
                out_err  <= conv_err;
            end
        end
    end

    // Saturating count of delivered results flagged as bad BCD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (v2 && out_ready && out_err && (err_cnt != {CW{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_gray_code_stream_conv.sv
// tb/tb_gray_code_stream_conv.sv - self-checking bench for gray_code_stream_conv
module tb_gray_code_stream_conv;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // 4-bit instance with an 8-bit error counter
    logic       v4 = 1'b0, r4 = 1'b0, ir4, ov4, oe4;
    logic [3:0] d4 = '0, od4;
    logic [1:0] m4 = '0;
    logic [7:0] ec4;

    // 8-bit instance with a 2-bit error counter
    logic       v8 = 1'b0, r8 = 1'b0, ir8, ov8, oe8;
    logic [7:0] d8 = '0, od8;
    logic [1:0] m8 = '0;
    logic [1:0] ec8;

    gray_code_stream_conv #(.N(4), .CW(8)) u4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir4), .in_data(d4), .in_mode(m4),
        .out_valid(ov4), .out_ready(r4), .out_data(od4), .out_err(oe4), .err_cnt(ec4)
    );

    gray_code_stream_conv #(.N(8), .CW(2)) u8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8), .in_data(d8), .in_mode(m8),
        .out_valid(ov8), .out_ready(r8), .out_data(od8), .out_err(oe8), .err_cnt(ec8)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [8:0] q4[$];
    logic [8:0] q8[$];
    int         cnt4 = 0;
    int         cnt8 = 0;
    logic       stall_prev[2];
    logic [8:0] held[2];
    logic       obs_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: result word and BCD flag from the arithmetic definition of each mode
    function automatic logic [8:0] ref_conv(input int sel, input logic [7:0] d, input logic [1:0] m);
        int n, mask, x, r;
        logic e;
        n    = (sel != 0) ? 8 : 4;
        mask = (1 << n) - 1;
        x    = int'(d) & mask;
        r    = x;
        e    = 1'b0;
        case (m)
            2'd0, 2'd2: r = x ^ (x >> 1);
            2'd1: begin
                // the binary value whose Gray code equals x
                for (int b = 0; b <= mask; b++) begin
                    if (((b ^ (b >> 1)) & mask) == x) r = b;
                end
            end
            default: r = x;
        endcase
        if (m == 2'd2) begin
            for (int k = 0; k < n / 4; k++) begin
                if (((x >> (4 * k)) % 16) > 9) e = 1'b1;
            end
        end
        return {e, r[7:0]};
    endfunction

    // One clock: drive inputs, score the output handshake, then check err_cnt after the edge
    task automatic step(input int sel, input logic v, input logic [7:0] d, input logic [1:0] m,
                        input logic ordy);
        logic       cv, cerr;
        logic [7:0] cd;
        logic [8:0] e;
        int         sat;
        if (sel == 0) begin
            v4 = v; d4 = d[3:0]; m4 = m; r4 = ordy; v8 = 1'b0; r8 = 1'b0;
        end else begin
            v8 = v; d8 = d; m8 = m; r8 = ordy; v4 = 1'b0; r4 = 1'b0;
        end
        #1;
        if (sel == 0) begin
            cv = ov4; cd = {4'h0, od4}; cerr = oe4; obs_ready = ir4;
        end else begin
            cv = ov8; cd = od8; cerr = oe8; obs_ready = ir8;
        end
        if (stall_prev[sel]) check("hold_stable", {cv, cerr, cd}, {1'b1, held[sel]});
        if (cv && ordy) begin
            if ((sel == 0 && q4.size() == 0) || (sel != 0 && q8.size() == 0)) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                e = (sel == 0) ? q4.pop_front() : q8.pop_front();
                check("out_word", {cerr, cd}, e);
                sat = (sel == 0) ? 255 : 3;
                if (e[8]) begin
                    if (sel == 0) cnt4 = (cnt4 < sat) ? cnt4 + 1 : sat;
                    else          cnt8 = (cnt8 < sat) ? cnt8 + 1 : sat;
                end
            end
        end
        stall_prev[sel] = cv && !ordy;
        held[sel]       = {cerr, cd};
        if (v && obs_ready) begin
            if (sel == 0) q4.push_back(ref_conv(0, d, m));
            else          q8.push_back(ref_conv(1, d, m));
        end
        @(posedge clk);
        #1;
        if (sel == 0) check("err_cnt4", ec4, cnt4);
        else          check("err_cnt8", ec8, cnt8);
    endtask

    task automatic expect_out(input int sel, input logic [7:0] d, input logic e);
        if (sel == 0) check("direct4", {ov4, oe4, 4'h0, od4}, {1'b1, e, d});
        else          check("direct8", {ov8, oe8, od8}, {1'b1, e, d});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v4 = 1'b0; v8 = 1'b0; r4 = 1'b0; r8 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        q4.delete(); q8.delete();
        cnt4 = 0; cnt8 = 0;
        stall_prev[0] = 1'b0; stall_prev[1] = 1'b0;
        rst = 1'b0;
    endtask

    logic [31:0] rnd;
    logic [3:0]  g;
    int          idx;
    logic        saw_block;

    initial begin
        do_reset();
        check("rst_u4", {ov4, oe4, od4, ec4, ir4}, {1'b0, 1'b0, 4'h0, 8'h00, 1'b1});
        check("rst_u8", {ov8, oe8, od8, ec8, ir8}, {1'b0, 1'b0, 8'h00, 2'b00, 1'b1});

        // Basic conversions, two-edge latency
        step(0, 1'b1, 8'h06, 2'd0, 1'b1);
        step(0, 1'b0, 8'h00, 2'd0, 1'b1);
        expect_out(0, 8'h05, 1'b0);
        step(0, 1'b1, 8'h05, 2'd1, 1'b1);
        step(0, 1'b0, 8'h00, 2'd0, 1'b1);
        expect_out(0, 8'h06, 1'b0);
        step(0, 1'b1, 8'h08, 2'd1, 1'b1);
        step(0, 1'b0, 8'h00, 2'd0, 1'b1);
        expect_out(0, 8'h0F, 1'b0);
        step(0, 1'b0, 8'h00, 2'd0, 1'b1);

        // Exhaustive round trip with the Gray result fed back in
        for (int b = 0; b < 16; b++) begin
            step(0, 1'b1, 8'(b), 2'd0, 1'b1);
            step(0, 1'b0, 8'h00, 2'd0, 1'b1);
            g = od4;
            step(0, 1'b1, {4'h0, g}, 2'd1, 1'b1);
            step(0, 1'b0, 8'h00, 2'd0, 1'b1);
            expect_out(0, 8'(b), 1'b0);
        end
        step(0, 1'b0, 8'h00, 2'd0, 1'b1);

        // Mixed modes on 0xA at one sample per clock
        step(0, 1'b1, 8'h0A, 2'd3, 1'b1);
        step(0, 1'b1, 8'h0A, 2'd0, 1'b1);
        expect_out(0, 8'h0A, 1'b0);
        step(0, 1'b1, 8'h0A, 2'd1, 1'b1);
        expect_out(0, 8'h0F, 1'b0);
        step(0, 1'b0, 8'h00, 2'd0, 1'b1);
        expect_out(0, 8'h0C, 1'b0);
        step(0, 1'b0, 8'h00, 2'd0, 1'b1);

        // Random traffic on the 4-bit instance
        for (int i = 0; i < 300; i++) begin
            rnd = $urandom;
            step(0, rnd[0] | rnd[1], rnd[15:8], rnd[17:16], rnd[20] | rnd[21]);
        end
        for (int i = 0; i < 4; i++) step(0, 1'b0, 8'h00, 2'd0, 1'b1);
        check("drain_u4", q4.size(), 0);

        // BCD mode on the 8-bit instance
        step(1, 1'b1, 8'h59, 2'd2, 1'b1);
        step(1, 1'b0, 8'h00, 2'd0, 1'b1);
        expect_out(1, 8'h75, 1'b0);
        step(1, 1'b1, 8'h5A, 2'd2, 1'b1);
        check("bcd_cnt_before", ec8, 0);
        step(1, 1'b0, 8'h00, 2'd0, 1'b1);
        expect_out(1, 8'h77, 1'b1);
        step(1, 1'b0, 8'h00, 2'd0, 1'b1);
        check("bcd_cnt_after", ec8, 1);

        // Asynchronous reset with both stages occupied
        step(1, 1'b1, 8'h12, 2'd3, 1'b0);
        step(1, 1'b1, 8'h34, 2'd3, 1'b0);
        check("full_before_rst", {ov8, ir8}, {1'b1, 1'b0});
        rst = 1'b1;
        #1;
        check("async_rst", {ov8, ec8, ir8}, {1'b0, 2'b00, 1'b1});
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 1'b0, 8'h00, 2'd0, 1'b1);
            check("no_stale", ov8, 1'b0);
        end

        // Saturating error counter with CW=2
        for (int k = 1; k <= 5; k++) begin
            step(1, 1'b1, 8'hAB, 2'd2, 1'b1);
            step(1, 1'b0, 8'h00, 2'd0, 1'b1);
            step(1, 1'b0, 8'h00, 2'd0, 1'b1);
            check("sat_seq", ec8, (k > 3) ? 3 : k);
        end

        // Backpressure: six samples with out_ready low for three cycles
        idx = 0;
        saw_block = 1'b0;
        for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
            rnd = $urandom;
            step(1, 1'b1, 8'(8'h31 + idx * 8'h13), rnd[1:0], !(cyc >= 2 && cyc < 5));
            if (obs_ready) idx++;
            else           saw_block = 1'b1;
        end
        check("bp_sent", idx, 6);
        check("bp_in_ready_dropped", saw_block, 1'b1);
        for (int i = 0; i < 6; i++) step(1, 1'b0, 8'h00, 2'd0, 1'b1);
        check("bp_drain", q8.size(), 0);

        // Random traffic on the 8-bit instance
        for (int i = 0; i < 400; i++) begin
            rnd = $urandom;
            step(1, rnd[0] | rnd[1], rnd[15:8], rnd[17:16], rnd[20] | rnd[21]);
        end
        for (int i = 0; i < 4; i++) step(1, 1'b0, 8'h00, 2'd0, 1'b1);
        check("drain_u8", q8.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
